// File: rtl/fft_pkg.sv
// ============================================================================
// Module      : fft_pkg
// Description : Shared types and frame-size helpers for the FFT stage RAMs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_pkg;

    localparam int ADDR_W_DEF = 10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2,
        S_BOTH   = 2'd3
    } pp_state_t;

    // Pairs per frame: each bank address holds one half of a pair.
    function automatic int frame_pairs(input int addr_w);
        return 1 << (addr_w - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fullAdder10b.sv
// ============================================================================
// Module      : fullAdder10b
// Description : 10-bit ripple-style adder with carry in/out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fullAdder10b (
    input  logic [9:0] a,
    input  logic [9:0] b,
    input  logic       cin,
    output logic [9:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {10'd0, cin};

endmodule

`default_nettype wire

// File: rtl/pp_addr_split.sv
// ============================================================================
// Module      : pp_addr_split
// Description : Builds the A/B RAM address pair by inserting a select bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pp_addr_split #(
    parameter int ADDR_W = 10,
    parameter int SPLIT  = 2
) (
    input  logic [ADDR_W-2:0] cnt,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b
);

    assign addr_a = {cnt[ADDR_W-2:SPLIT], 1'b0, cnt[SPLIT-1:0]};
    assign addr_b = {cnt[ADDR_W-2:SPLIT], 1'b1, cnt[SPLIT-1:0]};

endmodule

`default_nettype wire

// File: rtl/pingpong_bank_ctrl.sv
// ============================================================================
// Module      : pingpong_bank_ctrl
// Description : Ping-pong bank write/read scheduler for one FFT stage.
//               PINGPONG_OVF_DET_EN enables overrun suppression and flagging.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pingpong_bank_ctrl
    import fft_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int WR_SPLIT = 2,
    parameter int RD_SPLIT = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_valid,
    input  logic              i_rd_ready,
    output logic              o_we_b0,
    output logic              o_we_b1,
    output logic [ADDR_W-1:0] o_wr_addr_a,
    output logic [ADDR_W-1:0] o_wr_addr_b,
    output logic [ADDR_W-1:0] o_rd_addr_a,
    output logic [ADDR_W-1:0] o_rd_addr_b,
    output logic              o_rd_bank,
    output logic              o_rd_strobe,
    output logic              o_data_valid,
    output logic              o_frame_done,
    output logic              o_overflow,
    output logic [1:0]        o_state
);

    localparam int CNT_W = ADDR_W - 1;
    localparam int PAD_W = 10 - CNT_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(frame_pairs(ADDR_W) - 1);

    pp_state_t        state, state_next;
    logic [CNT_W-1:0] wr_cnt, rd_cnt, wr_cnt_inc, rd_cnt_inc;
    logic [PAD_W-1:0] wr_hi_unused, rd_hi_unused;
    logic             wr_carry_unused, rd_carry_unused;
    logic             wr_bank, rd_bank;
    logic [1:0]       full, full_next;
    logic             wr_last, rd_last, rd_issue, we_ok, dv_pipe;
    logic [ADDR_W-1:0] wr_addr_a, wr_addr_b, rd_addr_a, rd_addr_b;

    fullAdder10b u_wr_inc (
        .a    (10'(wr_cnt)),
        .b    (10'd0),
        .cin  (1'b1),
        .sum  ({wr_hi_unused, wr_cnt_inc}),
        .cout (wr_carry_unused)
    );

    fullAdder10b u_rd_inc (
        .a    (10'(rd_cnt)),
        .b    (10'd0),
        .cin  (1'b1),
        .sum  ({rd_hi_unused, rd_cnt_inc}),
        .cout (rd_carry_unused)
    );

    pp_addr_split #(.ADDR_W(ADDR_W), .SPLIT(WR_SPLIT)) u_wr_split (
        .cnt    (wr_cnt),
        .addr_a (wr_addr_a),
        .addr_b (wr_addr_b)
    );

    pp_addr_split #(.ADDR_W(ADDR_W), .SPLIT(RD_SPLIT)) u_rd_split (
        .cnt    (rd_cnt),
        .addr_a (rd_addr_a),
        .addr_b (rd_addr_b)
    );

    assign wr_last  = (wr_cnt == CNT_LAST);
    assign rd_last  = (rd_cnt == CNT_LAST);
    assign rd_issue = full[rd_bank] && i_rd_ready;

`ifdef PINGPONG_OVF_DET_EN
    logic overrun, overflow;
    assign overrun    = i_wr_valid && full[wr_bank];
    assign we_ok      = i_wr_valid && !full[wr_bank];
    assign o_overflow = overflow;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)     overflow <= 1'b0;
        else if (overrun) overflow <= 1'b1;
    end
`else
    assign we_ok      = i_wr_valid;
    assign o_overflow = 1'b0;
`endif

    // Clear first so a same-bank set in the same cycle takes priority.
    always_comb begin
        full_next = full;
        if (rd_issue && rd_last)
            full_next[rd_bank] = 1'b0;
        if (i_wr_valid && wr_last)
            full_next[wr_bank] = 1'b1;
    end

    always_comb begin
        state_next = state;
        if (state == S_IDLE) begin
            if (i_wr_valid)
                state_next = S_FILL;
        end else begin
            case (full_next)
                2'b00:   state_next = S_FILL;
                2'b11:   state_next = S_BOTH;
                default: state_next = S_STREAM;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= S_IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            full         <= 2'b00;
            o_we_b0      <= 1'b0;
            o_we_b1      <= 1'b0;
            o_wr_addr_a  <= '0;
            o_wr_addr_b  <= '0;
            o_rd_addr_a  <= '0;
            o_rd_addr_b  <= '0;
            o_rd_bank    <= 1'b0;
            o_rd_strobe  <= 1'b0;
            o_frame_done <= 1'b0;
            dv_pipe      <= 1'b0;
            o_data_valid <= 1'b0;
        end else begin
            full         <= full_next;
            o_we_b0      <= we_ok && !wr_bank;
            o_we_b1      <= we_ok && wr_bank;
            o_rd_strobe  <= rd_issue;
            o_frame_done <= rd_issue && rd_last;
            dv_pipe      <= o_rd_strobe;
            o_data_valid <= dv_pipe;
            if (i_wr_valid) begin
                wr_cnt      <= wr_cnt_inc;
                o_wr_addr_a <= wr_addr_a;
                o_wr_addr_b <= wr_addr_b;
                if (wr_last)
                    wr_bank <= ~wr_bank;
            end
            if (rd_issue) begin
                rd_cnt      <= rd_cnt_inc;
                o_rd_addr_a <= rd_addr_a;
                o_rd_addr_b <= rd_addr_b;
                o_rd_bank   <= rd_bank;
                if (rd_last)
                    rd_bank <= ~rd_bank;
            end
        end
    end

    assign o_state = state;

endmodule

`default_nettype wire

// File: tb/tb_pingpong_bank_ctrl.sv
// ============================================================================
// Module      : tb_pingpong_bank_ctrl
// Description : Directed self-checking bench for pingpong_bank_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pingpong_bank_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       rd_ready = 1'b0;
    logic       we_b0, we_b1, rd_bank, rd_strobe, data_valid, frame_done, overflow;
    logic [9:0] wr_addr_a, wr_addr_b, rd_addr_a, rd_addr_b;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pingpong_bank_ctrl dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_wr_valid   (wr_valid),
        .i_rd_ready   (rd_ready),
        .o_we_b0      (we_b0),
        .o_we_b1      (we_b1),
        .o_wr_addr_a  (wr_addr_a),
        .o_wr_addr_b  (wr_addr_b),
        .o_rd_addr_a  (rd_addr_a),
        .o_rd_addr_b  (rd_addr_b),
        .o_rd_bank    (rd_bank),
        .o_rd_strobe  (rd_strobe),
        .o_data_valid (data_valid),
        .o_frame_done (frame_done),
        .o_overflow   (overflow),
        .o_state      (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_wa(input int k);
        return 32'(((k >> 2) << 3) | (k & 3));
    endfunction

    function automatic logic [31:0] exp_ra(input int k);
        return 32'(((k >> 3) << 4) | (k & 7));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},   {30'd0, we_b1, we_b0}, 32'd0);
        check({tag, "_wra"},  32'(wr_addr_a), 32'd0);
        check({tag, "_wrb"},  32'(wr_addr_b), 32'd0);
        check({tag, "_rda"},  32'(rd_addr_a), 32'd0);
        check({tag, "_rdb"},  32'(rd_addr_b), 32'd0);
        check({tag, "_flags"}, {27'd0, rd_bank, rd_strobe, data_valid, frame_done, overflow}, 32'd0);
        check({tag, "_state"}, 32'(state), 32'd0);
    endtask

    initial begin
        logic exp_ovf;
`ifdef PINGPONG_OVF_DET_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        // Reset state
        do_reset();
        check_all_zero("rst");

        // One full frame into bank 0, no reads
        for (int k = 0; k < 512; k++) begin
            wr_valid = 1'b1;
            step();
            check("t1_we0", 32'(we_b0), 32'd1);
            check("t1_we1", 32'(we_b1), 32'd0);
            check("t1_wra", 32'(wr_addr_a), exp_wa(k));
            check("t1_wrb", 32'(wr_addr_b), exp_wa(k) | 32'd4);
        end
        check("t1_state", 32'(state), 32'd2);
        step();
        check("t1_next_we1", 32'(we_b1), 32'd1);
        check("t1_no_read", 32'(rd_strobe), 32'd0);

        // Full-rate ping-pong for three frames
        do_reset();
        for (int c = 0; c < 2052; c++) begin
            wr_valid = (c < 1536);
            rd_ready = 1'b1;
            step();
            check("t2_we0", 32'(we_b0), 32'((c < 1536) && ((c / 512) % 2 == 0)));
            check("t2_we1", 32'(we_b1), 32'((c < 1536) && ((c / 512) % 2 == 1)));
            check("t2_strobe", 32'(rd_strobe), 32'((c >= 512) && (c < 2048)));
            check("t2_dvalid", 32'(data_valid), 32'((c >= 514) && (c < 2050)));
            check("t2_done", 32'(frame_done), 32'((c == 1023) || (c == 1535) || (c == 2047)));
            check("t2_ovf", 32'(overflow), 32'd0);
            if (c >= 512 && c < 2048) begin
                check("t2_rda", 32'(rd_addr_a), exp_ra((c - 512) % 512));
                check("t2_rdb", 32'(rd_addr_b), exp_ra((c - 512) % 512) | 32'd8);
                check("t2_rbank", 32'(rd_bank), 32'(((c - 512) / 512) % 2));
            end
        end

        // Both banks full, overrun, then simultaneous completions on bank 0
        do_reset();
        for (int k = 0; k < 1024; k++) begin
            wr_valid = 1'b1;
            step();
        end
        check("t3_state_both", 32'(state), 32'd3);
        check("t3_we1_last", 32'(we_b1), 32'd1);
        for (int e = 0; e < 512; e++) begin
            wr_valid = 1'b1;
            rd_ready = 1'b1;
            step();
            if (e == 0) begin
                check("t3_ovr_we0", 32'(we_b0), 32'(!exp_ovf));
                check("t3_ovr_flag", 32'(overflow), 32'(exp_ovf));
                check("t3_rda0", 32'(rd_addr_a), 32'd0);
            end
            check("t3_state", 32'(state), 32'd3);
            check("t3_done", 32'(frame_done), 32'(e == 511));
        end
        check("t3_ovf_hold", 32'(overflow), 32'(exp_ovf));
        wr_valid = 1'b0;
        step();
        check("t3_next_strobe", 32'(rd_strobe), 32'd1);
        check("t3_next_rbank", 32'(rd_bank), 32'd1);
        check("t3_next_rda", 32'(rd_addr_a), 32'd0);
        check("t3_next_rdb", 32'(rd_addr_b), 32'd8);
        check("t3_next_state", 32'(state), 32'd3);

        // Back-pressured read frame
        do_reset();
        for (int k = 0; k < 512; k++) begin
            wr_valid = 1'b1;
            step();
        end
        wr_valid = 1'b0;
        for (int e = 0; e < 1024; e++) begin
            rd_ready = (e % 2 == 0);
            step();
            check("t4_strobe", 32'(rd_strobe), 32'(e % 2 == 0));
            check("t4_done", 32'(frame_done), 32'(e == 1022));
            if (e % 2 == 0)
                check("t4_rda", 32'(rd_addr_a), exp_ra(e / 2));
        end
        check("t4_state_fill", 32'(state), 32'd1);

        // Reset mid-frame at wr_cnt = 200
        do_reset();
        for (int k = 0; k < 200; k++) begin
            wr_valid = 1'b1;
            step();
        end
        check("t5_wra_199", 32'(wr_addr_a), exp_wa(199));
        rst_n = 1'b0;
        step();
        check_all_zero("t5_rst");
        rst_n = 1'b1;
        wr_valid = 1'b1;
        step();
        check("t5_we0", 32'(we_b0), 32'd1);
        check("t5_we1", 32'(we_b1), 32'd0);
        check("t5_wra", 32'(wr_addr_a), 32'd0);
        check("t5_wrb", 32'(wr_addr_b), 32'd4);
        check("t5_state", 32'(state), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
